// File: rtl/switch_debounce_events.sv
// Per-channel switch debouncer with press/release edge detection and a show-ahead event FIFO.
// Edge events are queued through a pending-bit arbiter; a lost event raises a sticky overflow flag.
module switch_debounce_events #(
  parameter int N_CH       = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_CH-1:0]               raw_state,
  output logic [N_CH-1:0]               stable_state,
  output logic                          evt_valid,
  output logic [3:0]                    evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [N_CH-1:0]  stable_r;
  logic [CNT_W-1:0] cnt_r [N_CH];
  logic [N_CH-1:0]  pend_r;
  logic [N_CH-1:0]  pend_pol_r;
  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             evt_valid_r;
  logic [3:0]       evt_data_r;
  logic             overflow_r;

  logic [CNT_W-1:0] cnt_next_s [N_CH];
  logic [N_CH-1:0]  flip_s;
  logic [N_CH-1:0]  grant_s;
  logic [N_CH-1:0]  collision_s;
  logic [N_CH-1:0]  pend_next_s;
  logic [N_CH-1:0]  pend_pol_next_s;
  logic             found_s;
  logic             pop_s;
  logic             push_s;
  logic             can_push_s;
  logic [3:0]       push_data_s;
  logic [PTR_W:0]   count_next_s;
  logic [PTR_W:0]   remain_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic             valid_next_s;
  logic [3:0]       data_next_s;
  logic             overflow_next_s;

  // Debounce counters: a mismatch must persist DEB_CYCLES enabled cycles before the level flips.
  always_comb begin
    flip_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (sync2_r[i] == stable_r[i]) begin
        cnt_next_s[i] = '0;
      end else if (enable) begin
        if (cnt_r[i] == DEB_LAST) begin
          flip_s[i]     = 1'b1;
          cnt_next_s[i] = '0;
        end else begin
          cnt_next_s[i] = cnt_r[i] + 1'b1;
        end
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Lowest-index pending event wins; a full FIFO accepts only when it is popped in the same cycle.
  always_comb begin
    pop_s       = evt_valid_r & evt_ready;
    can_push_s  = (count_r < DEPTH_C) || pop_s;
    grant_s     = '0;
    found_s     = 1'b0;
    push_data_s = 4'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (can_push_s && pend_r[i] && !found_s) begin
        found_s     = 1'b1;
        grant_s[i]  = 1'b1;
        push_data_s = {pend_pol_r[i], 3'(i)};
      end else begin
        found_s = found_s;
      end
    end
    push_s = found_s;
  end

  // Pending bits: a new flip always wins over a same-cycle grant; flipping an ungranted pend loses the old event.
  always_comb begin
    pend_next_s     = pend_r;
    pend_pol_next_s = pend_pol_r;
    collision_s     = flip_s & pend_r & ~grant_s;
    for (int i = 0; i < N_CH; i++) begin
      if (flip_s[i]) begin
        pend_next_s[i]     = 1'b1;
        pend_pol_next_s[i] = ~stable_r[i];
      end else if (grant_s[i]) begin
        pend_next_s[i] = 1'b0;
      end else begin
        pend_next_s[i] = pend_r[i];
      end
    end
    if (|collision_s) begin
      overflow_next_s = 1'b1;
    end else if (clear_overflow) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // FIFO bookkeeping; a freshly pushed entry becomes visible at the head one cycle after it is written.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
    rd_ptr_next_s = pop_s ? (rd_ptr_r + 1'b1) : rd_ptr_r;
    remain_s      = count_r - {{PTR_W{1'b0}}, pop_s};
    valid_next_s  = (remain_s != '0);
    if (valid_next_s) begin
      data_next_s = mem_r[rd_ptr_next_s];
    end else begin
      data_next_s = 4'd0;
    end
  end

  // Event storage array; contents are only observed through the valid-qualified head register.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r     <= '0;
      sync2_r     <= '0;
      stable_r    <= '0;
      pend_r      <= '0;
      pend_pol_r  <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      evt_valid_r <= 1'b0;
      evt_data_r  <= 4'd0;
      overflow_r  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r     <= raw_state;
      sync2_r     <= sync1_r;
      stable_r    <= stable_r ^ flip_s;
      pend_r      <= pend_next_s;
      pend_pol_r  <= pend_pol_next_s;
      wr_ptr_r    <= push_s ? (wr_ptr_r + 1'b1) : wr_ptr_r;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      evt_valid_r <= valid_next_s;
      evt_data_r  <= data_next_s;
      overflow_r  <= overflow_next_s;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  assign stable_state = stable_r;
  assign evt_valid    = evt_valid_r;
  assign evt_data     = evt_data_r;
  assign fifo_count   = count_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_switch_debounce_events.sv
// Directed bench for switch_debounce_events with DEB_CYCLES=4 and an 8-entry FIFO.
module tb_switch_debounce_events;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] raw_state;
  logic [7:0] stable_state;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clear_overflow;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp5 [9] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
  logic [3:0] exp6 [9] = '{4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h2};

  switch_debounce_events #(.N_CH(8), .DEB_CYCLES(4), .CNT_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .raw_state(raw_state),
    .stable_state(stable_state), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .fifo_count(fifo_count), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] raw);
    reset     = 1'b0;
    raw_state = raw;
    step(2);
    reset     = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; evt_ready = 1'b0; clear_overflow = 1'b0; raw_state = 8'hFF;
    // 1. reset state, then release with all switches high
    step(2);
    chk("rst_stable", stable_state, 8'h00);
    chk("rst_valid", {7'd0, evt_valid}, 8'h00);
    chk("rst_data", {4'd0, evt_data}, 8'h00);
    chk("rst_count", {4'd0, fifo_count}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    reset = 1'b1;
    step(5);
    chk("t1_stable_e5", stable_state, 8'h00);
    step(1);
    chk("t1_stable_e6", stable_state, 8'hFF);
    step(1);
    chk("t1_count_e7", {4'd0, fifo_count}, 8'h01);
    chk("t1_valid_e7", {7'd0, evt_valid}, 8'h00);
    step(1);
    chk("t1_valid_e8", {7'd0, evt_valid}, 8'h01);
    chk("t1_data_e8", {4'd0, evt_data}, 8'h08);
    do_reset(8'h00);
    chk("midrst_count", {4'd0, fifo_count}, 8'h00);
    chk("midrst_valid", {7'd0, evt_valid}, 8'h00);
    chk("midrst_stable", stable_state, 8'h00);

    // 2. single press on ch3 and pop
    step(3);
    raw_state = 8'h08;
    step(5);
    chk("t2_stable_e5", stable_state, 8'h00);
    step(1);
    chk("t2_stable_e6", stable_state, 8'h08);
    step(1);
    chk("t2_count_e7", {4'd0, fifo_count}, 8'h01);
    chk("t2_valid_e7", {7'd0, evt_valid}, 8'h00);
    step(1);
    chk("t2_valid_e8", {7'd0, evt_valid}, 8'h01);
    chk("t2_data_e8", {4'd0, evt_data}, 8'h0B);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t2_valid_pop", {7'd0, evt_valid}, 8'h00);
    chk("t2_count_pop", {4'd0, fifo_count}, 8'h00);
    chk("t2_data_pop", {4'd0, evt_data}, 8'h00);

    // 3. ch5 bouncing every 3 cycles, then enable gap mid-count
    for (int k = 0; k < 4; k++) begin
      raw_state = 8'h28;
      step(3);
      raw_state = 8'h08;
      step(3);
    end
    step(4);
    chk("t3_bounce_stable", stable_state, 8'h08);
    chk("t3_bounce_count", {4'd0, fifo_count}, 8'h00);
    raw_state = 8'h28;
    step(4);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(1);
    chk("t3_en_stable_e8", stable_state, 8'h08);
    step(1);
    chk("t3_en_stable_e9", stable_state, 8'h28);
    step(2);
    chk("t3_valid", {7'd0, evt_valid}, 8'h01);
    chk("t3_data", {4'd0, evt_data}, 8'h0D);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t3_valid_pop", {7'd0, evt_valid}, 8'h00);

    // 4. ch0 and ch7 together: ch0 pushed first
    do_reset(8'h00);
    raw_state = 8'h81;
    step(6);
    chk("t4_stable", stable_state, 8'h81);
    step(1);
    chk("t4_count_e7", {4'd0, fifo_count}, 8'h01);
    step(1);
    chk("t4_count_e8", {4'd0, fifo_count}, 8'h02);
    chk("t4_valid_e8", {7'd0, evt_valid}, 8'h01);
    chk("t4_data_first", {4'd0, evt_data}, 8'h08);
    evt_ready = 1'b1;
    step(1);
    chk("t4_data_second", {4'd0, evt_data}, 8'h0F);
    chk("t4_count_pop1", {4'd0, fifo_count}, 8'h01);
    step(1);
    evt_ready = 1'b0;
    chk("t4_valid_end", {7'd0, evt_valid}, 8'h00);
    chk("t4_count_end", {4'd0, fifo_count}, 8'h00);

    // 5. ten events with no pops: 8 queued, 2 pending held
    do_reset(8'h00);
    raw_state = 8'hFF;
    step(14);
    chk("t5_count_full", {4'd0, fifo_count}, 8'h08);
    raw_state = 8'hFC;
    step(8);
    chk("t5_stable", stable_state, 8'hFC);
    chk("t5_count_held", {4'd0, fifo_count}, 8'h08);
    chk("t5_ovf", {7'd0, overflow}, 8'h00);
    chk("t5_head", {4'd0, evt_data}, 8'h08);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t5_count_pushpop", {4'd0, fifo_count}, 8'h08);
    chk("t5_head2", {4'd0, evt_data}, 8'h09);
    step(1);
    chk("t5_count_after", {4'd0, fifo_count}, 8'h08);
    evt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t5_drain_valid%0d", k), {7'd0, evt_valid}, 8'h01);
      chk($sformatf("t5_drain_data%0d", k), {4'd0, evt_data}, {4'd0, exp5[k]});
      step(1);
    end
    evt_ready = 1'b0;
    chk("t5_empty_valid", {7'd0, evt_valid}, 8'h00);
    chk("t5_empty_count", {4'd0, fifo_count}, 8'h00);

    // 6. pending collisions on ch2 while full, overflow set/clear priority
    do_reset(8'h00);
    raw_state = 8'hFB;
    step(14);
    chk("t6_count7", {4'd0, fifo_count}, 8'h07);
    raw_state = 8'hFA;
    step(8);
    chk("t6_count8", {4'd0, fifo_count}, 8'h08);
    raw_state = 8'hFE;
    step(8);
    chk("t6_stable_press", stable_state, 8'hFE);
    chk("t6_ovf_none", {7'd0, overflow}, 8'h00);
    raw_state = 8'hFA;
    step(5);
    chk("t6_ovf_e5", {7'd0, overflow}, 8'h00);
    step(1);
    chk("t6_ovf_set", {7'd0, overflow}, 8'h01);
    chk("t6_stable_rel", stable_state, 8'hFA);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("t6_ovf_clr", {7'd0, overflow}, 8'h00);
    raw_state = 8'hFE;
    step(5);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("t6_ovf_setwins", {7'd0, overflow}, 8'h01);
    step(1);
    chk("t6_ovf_sticky", {7'd0, overflow}, 8'h01);
    raw_state = 8'hFA;
    step(6);
    chk("t6_ovf_again", {7'd0, overflow}, 8'h01);
    chk("t6_count_again", {4'd0, fifo_count}, 8'h08);
    evt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t6_drain_valid%0d", k), {7'd0, evt_valid}, 8'h01);
      chk($sformatf("t6_drain_data%0d", k), {4'd0, evt_data}, {4'd0, exp6[k]});
      step(1);
    end
    evt_ready = 1'b0;
    chk("t6_empty_valid", {7'd0, evt_valid}, 8'h00);
    chk("t6_empty_count", {4'd0, fifo_count}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
